js_decoder: RTL and testbench
=============================

// Module: js_decoder
// PURPOSE
//  Receive end of the Johnson-counter link: takes a stream of Johnson-coded words, checks
//  legality and sequence continuity, and emits the binary step index 0..2*DATA_WID-1.
//  Tracks sequence lock with a small FSM so downstream logic trusts the index only while locked.
//  Sits directly after the Johnson counter / its transport, one word per in_valid cycle.
// PARAMETERS
//  DATA_WID  8  Johnson word width (>=2); sequence length 2*DATA_WID
//  LOCK_CNT  4  consecutive good words needed to enter LOCKED (>=1)
//  IDX_W     $clog2(2*DATA_WID)  index width, derived (localparam, not overridable)
// PORTS
//  clk        in   1         clock, rising edge
//  rst_n      in   1         asynchronous active-low reset
//  in_valid   in   1         in_data carries a word this cycle
//  in_data    in   DATA_WID  Johnson-coded word
//  out_valid  out  1         result registered from previous in_valid cycle
//  out_index  out  IDX_W     decoded step index (0 when illegal)
//  illegal    out  1         word not a legal Johnson code
//  seq_err    out  1         legal word but not successor of last legal word
//  locked     out  1         FSM in LOCKED
// BEHAVIOUR
//  Sequence: next = {cur[DATA_WID-2:0], ~cur[DATA_WID-1]}; 00..0 is index 0.
//  Legal iff word is 0..01..1 (incl. all-0/all-1) or 1..10..0.
//  Index: MSB=0 -> popcount; MSB=1 -> 2*DATA_WID - popcount. (8b: 11111110 -> 9, 10000000 -> 15).
//  Latency 1 cycle: in_valid at edge N -> out_valid/out_index/flags valid after edge N.
//  in_valid=0: out_valid=0 next cycle; illegal/seq_err cleared; out_index, FSM, prev held.
//  prev register + have_prev flag: loaded on every legal word; illegal clears have_prev.
//  seq_err=1 only if legal & have_prev & in_data != next(prev); never with illegal.
//  Wrap: prev=10..0 followed by 00..0 is in sequence (index 2N-1 -> 0).
//  Good word = legal & !seq_err (first word after reset/illegal counts as good).
//  run counter: +1 on good word (saturates at LOCK_CNT), cleared on illegal or seq_err.
//  FSM UNLOCKED -> LOCKED on the good word that makes run == LOCK_CNT; locked rises with
//    that word's out_valid. LOCKED -> UNLOCKED on any illegal or seq_err (same out_valid cycle).
//  Repeated identical word = seq_err (counter never stalls in-sequence).
//  Reset (async, any time incl. mid-stream): all outputs 0, FSM UNLOCKED, run=0,
//    have_prev=0, prev=0; first word after release treated as first word.
// CONFIGURATION
//  JSD_ERR_CNT_EN defined: adds output err_count [7:0]; +1 per illegal or seq_err word,
//    saturates at 255, cleared only by reset.
//  Not defined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  js_pkg: FSM state encodings (ST_UNLOCKED, ST_LOCKED), js_next() successor function,
//    IDX_W calculation; shared with the Johnson counter and its bench.
//  Sub-module js_code_check: combinational legality + index from one word; js_decoder
//    holds prev/have_prev, run counter, FSM, output registers.
// TESTING (DATA_WID=8, LOCK_CNT=4)
//  Reset then 00000000,00000001,00000011,00000111 -> index 0,1,2,3; locked rises with 4th.
//  Full 16-step cycle ending 10000000 then 00000000 -> index 15 then 0, no seq_err, stays locked.
//  Locked, inject 00000101 -> illegal=1, index 0, locked=0; next 00000001 good, run=1.
//  Locked at 00000011, send 00011111 -> seq_err=1, index 5, locked=0; 00111111 then good.
//  in_valid gaps between words -> out_valid 0 in gaps, lock and sequence unaffected.
//  rst_n low mid-stream while locked -> all outputs 0 immediately; relock needs 4 good words.

Source files
------------

// File: rtl/js_pkg.sv
// Shared Johnson-code definitions: lock FSM states, successor function, index width.
// Used by the Johnson counter, js_decoder and their benches.
package js_pkg;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } js_state_e;

    // Widest word js_next() handles; callers cast their word in and back out.
    localparam int JS_MAX_W = 32;

    function automatic int js_idx_w(input int data_wid);
        return $clog2(2 * data_wid);
    endfunction

    // Johnson successor: shift left, feed back the inverted MSB; bits above data_wid cleared.
    function automatic logic [JS_MAX_W-1:0] js_next(input logic [JS_MAX_W-1:0] cur,
                                                    input int data_wid);
        logic [JS_MAX_W-1:0] nxt;
        nxt = {cur[JS_MAX_W-2:0], ~cur[data_wid-1]};
        for (int i = 0; i < JS_MAX_W; i++)
            if (i >= data_wid) nxt[i] = 1'b0;
        return nxt;
    endfunction

endpackage

// File: rtl/js_code_check.sv
// Combinational legality check and step-index decode for one Johnson-coded word.
module js_code_check #(
    parameter int DATA_WID = 8,
    parameter int IDX_W    = 4
) (
    input  logic [DATA_WID-1:0] word,
    output logic                legal,
    output logic [IDX_W-1:0]    index
);

    logic [DATA_WID-1:0] inv;
    logic                fill_lo;
    logic                fill_hi;
    logic [IDX_W:0]      pop;

    assign inv = ~word;

    // 0..01..1 has no set bit above its lowest clear bit; 1..10..0 is the inverse shape.
    assign fill_lo = ((word & (word + DATA_WID'(1))) == '0);
    assign fill_hi = ((inv & (inv + DATA_WID'(1))) == '0);
    assign legal   = fill_lo | fill_hi;

    always_comb begin
        pop = '0;
        for (int i = 0; i < DATA_WID; i++)
            pop = pop + (IDX_W+1)'(word[i]);
    end

    always_comb begin
        index = '0;
        if (legal) begin
            if (word[DATA_WID-1]) index = IDX_W'(2 * DATA_WID - int'(pop));
            else                  index = IDX_W'(pop);
        end
    end

endmodule

// File: rtl/js_decoder.sv
// Johnson-link receiver: legality + continuity check, index decode, sequence-lock FSM.
// Optional JSD_ERR_CNT_EN adds a saturating err_count output. DATA_WID must be <= 32.
module js_decoder
    import js_pkg::*;
#(
    parameter  int DATA_WID = 8,
    parameter  int LOCK_CNT = 4,
    localparam int IDX_W    = js_idx_w(DATA_WID)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [DATA_WID-1:0] in_data,
    output logic                out_valid,
    output logic [IDX_W-1:0]    out_index,
    output logic                illegal,
    output logic                seq_err,
`ifdef JSD_ERR_CNT_EN
    output logic [7:0]          err_count,
`endif
    output logic                locked
);

    localparam int RUN_W = $clog2(LOCK_CNT + 1);

    logic                chk_legal;
    logic [IDX_W-1:0]    chk_index;
    logic [DATA_WID-1:0] prev;
    logic [DATA_WID-1:0] prev_succ;
    logic                have_prev;
    logic [RUN_W-1:0]    run;
    logic [RUN_W-1:0]    run_nxt;
    logic                seq_hit;
    logic                good;
    logic                bad;
    js_state_e           state;
    js_state_e           state_nxt;

    js_code_check #(
        .DATA_WID (DATA_WID),
        .IDX_W    (IDX_W)
    ) u_chk (
        .word  (in_data),
        .legal (chk_legal),
        .index (chk_index)
    );

    assign prev_succ = DATA_WID'(js_next(JS_MAX_W'(prev), DATA_WID));
    // A repeated word is out of sequence too; the link never stalls.
    assign seq_hit   = in_valid & chk_legal & have_prev & (in_data != prev_succ);
    assign good      = in_valid & chk_legal & ~seq_hit;
    assign bad       = in_valid & (~chk_legal | seq_hit);

    always_comb begin
        run_nxt = run;
        if (bad)
            run_nxt = '0;
        else if (good && run != RUN_W'(LOCK_CNT))
            run_nxt = run + RUN_W'(1);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_UNLOCKED: if (good && run_nxt == RUN_W'(LOCK_CNT)) state_nxt = ST_LOCKED;
            ST_LOCKED:   if (bad) state_nxt = ST_UNLOCKED;
            default:     state_nxt = ST_UNLOCKED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_UNLOCKED;
            run   <= '0;
        end else begin
            state <= state_nxt;
            run   <= run_nxt;
        end
    end

    assign locked = (state == ST_LOCKED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev      <= '0;
            have_prev <= 1'b0;
            out_valid <= 1'b0;
            out_index <= '0;
            illegal   <= 1'b0;
            seq_err   <= 1'b0;
        end else begin
            out_valid <= in_valid;
            illegal   <= in_valid & ~chk_legal;
            seq_err   <= seq_hit;
            if (in_valid) begin
                out_index <= chk_index;
                have_prev <= chk_legal;
                if (chk_legal) prev <= in_data;
            end
        end
    end

`ifdef JSD_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_count <= '0;
        else if (bad && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_js_decoder.sv
// Directed bench for js_decoder: table-driven model of the Johnson sequence plus literal checks.
module tb_js_decoder;

    localparam int DW = 8;
    localparam int LC = 4;
    localparam int IW = $clog2(2 * DW);
    localparam int SEQ_LEN = 2 * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic [IW-1:0] out_index;
    logic          illegal;
    logic          seq_err;
    logic          locked;
`ifdef JSD_ERR_CNT_EN
    logic [7:0]    err_count;
`endif

    js_decoder #(.DATA_WID(DW), .LOCK_CNT(LC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_index (out_index),
        .illegal   (illegal),
        .seq_err   (seq_err),
`ifdef JSD_ERR_CNT_EN
        .err_count (err_count),
`endif
        .locked    (locked)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: the sequence as a table of words, position in the table is the index.
    logic [DW-1:0] tbl [SEQ_LEN];
    bit m_have = 0;
    int m_prev = 0;
    int m_run  = 0;
    bit m_lock = 0;
    bit e_valid = 0;
    bit e_ill = 0;
    bit e_seq = 0;
    int e_idx = 0;
    int e_errs = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lookup(input logic [DW-1:0] w);
        for (int k = 0; k < SEQ_LEN; k++)
            if (tbl[k] == w) return k;
        return -1;
    endfunction

    task automatic model_reset();
        m_have = 0; m_prev = 0; m_run = 0; m_lock = 0;
        e_valid = 0; e_ill = 0; e_seq = 0; e_idx = 0; e_errs = 0;
    endtask

    task automatic model_step(input bit v, input logic [DW-1:0] w);
        int k;
        e_valid = v;
        e_ill = 0;
        e_seq = 0;
        if (!v) return;
        k = lookup(w);
        if (k < 0) begin
            e_ill = 1; e_idx = 0; m_have = 0; m_run = 0; m_lock = 0;
            if (e_errs < 255) e_errs++;
        end else begin
            e_idx = k;
            e_seq = m_have && (k != (m_prev + 1) % SEQ_LEN);
            m_have = 1;
            m_prev = k;
            if (e_seq) begin
                m_run = 0; m_lock = 0;
                if (e_errs < 255) e_errs++;
            end else begin
                if (m_run < LC) m_run++;
                if (m_run == LC) m_lock = 1;
            end
        end
    endtask

    always @(negedge clk) begin
        chk("out_valid", out_valid, e_valid);
        chk("locked", locked, m_lock);
        chk("illegal", illegal, e_ill);
        chk("seq_err", seq_err, e_seq);
        if (e_valid) chk("out_index", out_index, e_idx);
`ifdef JSD_ERR_CNT_EN
        chk("err_count", err_count, e_errs);
`endif
    end

    task automatic send(input bit v, input logic [DW-1:0] w);
        in_valid = v;
        in_data  = w;
        @(posedge clk);
        model_step(v, w);
        #1;
    endtask

    task automatic sendc(input logic [DW-1:0] w, input int exp_idx, input int exp_lock);
        send(1'b1, w);
        chk("lit_index", out_index, exp_idx);
        chk("lit_locked", locked, exp_lock);
    endtask

    task automatic gap();
        send(1'b0, '0);
    endtask

    initial begin
        for (int k = 0; k < SEQ_LEN; k++)
            tbl[k] = (k <= DW) ? DW'((1 << k) - 1) : DW'(~((1 << (k - DW)) - 1));

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_index", out_index, 0);
        rst_n = 1'b1;

        // first words after reset, lock on the fourth
        sendc(8'b00000000, 0, 0);
        sendc(8'b00000001, 1, 0);
        sendc(8'b00000011, 2, 0);
        sendc(8'b00000111, 3, 1);

        // full cycle and wrap 15 -> 0
        for (int k = 4; k <= 8; k++) send(1'b1, tbl[k]);
        sendc(8'b11111110, 9, 1);
        for (int k = 10; k <= 14; k++) send(1'b1, tbl[k]);
        sendc(8'b10000000, 15, 1);
        sendc(8'b00000000, 0, 1);
        chk("wrap_seq", seq_err, 0);

        // illegal word drops lock, next word starts a fresh run
        sendc(8'b00000001, 1, 1);
        sendc(8'b00000011, 2, 1);
        sendc(8'b00000101, 0, 0);
        chk("ill_flag", illegal, 1);
        sendc(8'b00000001, 1, 0);
        chk("ill_recover", illegal | seq_err, 0);
        sendc(8'b00000011, 2, 0);
        sendc(8'b00000111, 3, 0);
        sendc(8'b00001111, 4, 1);

        // out-of-sequence legal word
        for (int k = 5; k <= 15; k++) send(1'b1, tbl[k]);
        sendc(8'b00000000, 0, 1);
        sendc(8'b00000001, 1, 1);
        sendc(8'b00000011, 2, 1);
        sendc(8'b00011111, 5, 0);
        chk("seq_flag", seq_err, 1);
        chk("seq_not_ill", illegal, 0);
        sendc(8'b00111111, 6, 0);
        chk("seq_recover", seq_err, 0);

        // gaps hold index and sequence; repeated word is a seq_err
        sendc(8'b01111111, 7, 0);
        gap();
        gap();
        chk("gap_valid", out_valid, 0);
        chk("gap_index", out_index, 7);
        sendc(8'b11111111, 8, 0);
        gap();
        sendc(8'b11111110, 9, 1);
        sendc(8'b11111110, 9, 0);
        chk("rep_seq", seq_err, 1);
        sendc(8'b11111100, 10, 0);
        sendc(8'b11111000, 11, 0);
        sendc(8'b11110000, 12, 0);
        sendc(8'b11100000, 13, 1);

        // asynchronous reset mid-stream while locked
        in_valid = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_locked", locked, 0);
        chk("arst_index", out_index, 0);
        chk("arst_flags", illegal | seq_err, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sendc(8'b11000000, 14, 0);
        sendc(8'b10000000, 15, 0);
        sendc(8'b00000000, 0, 0);
        sendc(8'b00000001, 1, 1);
        gap();
        repeat (2) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
